load_store_unit: RTL and testbench

Multi-cycle load/store unit between the execute stage and the word-addressed data memory. Accepts one byte-addressed load or store request at a time and checks alignment and funct3. Drives the memory with full-word accesses only, using read-modify-write for SB/SH. Extracts and sign/zero-extends loaded bytes and halfwords by byte offset, then returns the result with a one-cycle `done` pulse.

---
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle byte-addressed load/store front end for a
// word-addressed data memory. Sub-word stores use read-modify-write; loads
// extract and sign/zero-extend by byte offset. One request in flight.
module load_store_unit #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state, next_state;
  logic [2:0]        funct3_q, next_funct3_q;
  logic [1:0]        off_q, next_off_q;
  logic [15:0]       wdata_q, next_wdata_q;

  logic              next_busy, next_done, next_err;
  logic              next_mem_read, next_mem_write;
  logic [31:0]       next_rdata, next_mem_wdata;
  logic [ADDR_W-1:0] next_mem_addr;

  logic [1:0]        size;
  logic              legal, misaligned;
  logic [4:0]        lane_sh, half_sh;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       load_val, merged_sb, merged_sh, byte_mask, half_mask;

  // Byte-address bits above the memory window alias and are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  // Word access only toward memory.
  assign mem_funct3 = 3'b010;

  // Request decode: funct3 legality and natural alignment.
  always_comb begin
    size       = funct3[1:0];
    legal      = 1'b0;
    misaligned = 1'b0;
    if (is_store) legal = (funct3[2] == 1'b0) && (size != 2'b11);
    else          legal = (size != 2'b11) && !(funct3[2] && size == 2'b10);
    if (size == 2'b01 && addr[0])          misaligned = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) misaligned = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    lane_sh   = {off_q, 3'b000};
    half_sh   = {off_q[1], 4'b0000};
    byte_v    = 8'(mem_rdata >> lane_sh);
    half_v    = 16'(mem_rdata >> half_sh);
    byte_mask = DATA_W'(32'h0000_00FF) << lane_sh;
    half_mask = DATA_W'(32'h0000_FFFF) << half_sh;
    merged_sb = (mem_rdata & ~byte_mask) | (DATA_W'(wdata_q[7:0]) << lane_sh);
    merged_sh = (mem_rdata & ~half_mask) | (DATA_W'(wdata_q) << half_sh);
    case (funct3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'd0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = mem_rdata;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    next_state     = state;
    next_funct3_q  = funct3_q;
    next_off_q     = off_q;
    next_wdata_q   = wdata_q;
    next_err       = err;
    next_rdata     = rdata;
    next_mem_addr  = mem_addr;
    next_mem_wdata = mem_wdata;
    case (state)
      S_IDLE: begin
        if (req) begin
          next_funct3_q = funct3;
          next_off_q    = addr[1:0];
          next_wdata_q  = wdata[15:0];
          next_mem_addr = addr[ADDR_W+1:2];
          next_err      = 1'b0;
          next_rdata    = 32'd0;
          if (!legal || misaligned) begin
            next_err   = 1'b1;
            next_state = S_RESP;
          end else if (!is_store) begin
            next_state = S_LOAD;
          end else if (size == 2'b10) begin
            next_mem_wdata = wdata;
            next_state     = S_WRITE;
          end else begin
            next_state = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        next_rdata = load_val;
        next_state = S_RESP;
      end
      S_RMW_RD: begin
        next_mem_wdata = funct3_q[0] ? merged_sh : merged_sb;
        next_state     = S_WRITE;
      end
      S_WRITE: next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    next_busy      = (next_state != S_IDLE);
    next_done      = (next_state == S_RESP);
    next_mem_read  = (next_state == S_LOAD) || (next_state == S_RMW_RD);
    next_mem_write = (next_state == S_WRITE);
  end

  // State and registered outputs; reset aborts any access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      wdata_q   <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      state     <= next_state;
      funct3_q  <= next_funct3_q;
      off_q     <= next_off_q;
      wdata_q   <= next_wdata_q;
      busy      <= next_busy;
      done      <= next_done;
      err       <= next_err;
      rdata     <= next_rdata;
      mem_read  <= next_mem_read;
      mem_write <= next_mem_write;
      mem_addr  <= next_mem_addr;
      mem_wdata <= next_mem_wdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural byte-array memory model, directed
// cases plus randomized requests with aliased upper address bits.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NWORDS = 64;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic              is_store;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] mem     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  int n_checks;
  int n_fail;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write at posedge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] = mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: what the request should do, from the access rules alone.
  task automatic model(input bit st, input int f3, input logic [31:0] a, input logic [31:0] wd,
                       output bit e_err, output logic [31:0] e_rdata, output int e_lat,
                       output int e_rd_cyc, output int e_wr_cyc);
    int size, off, wi;
    bit legal, mis;
    logic [7:0] b [4];
    size = f3 % 4;
    off  = int'(a % 4);
    wi   = int'((a / 4) % NWORDS);
    legal = st ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    mis   = (size == 1 && (off % 2) != 0) || (size == 2 && off != 0);
    e_err = 0; e_rdata = 0; e_rd_cyc = 0; e_wr_cyc = 0;
    for (int i = 0; i < 4; i++) b[i] = ref_mem[wi][8*i +: 8];
    if (!legal || mis) begin
      e_err = 1; e_lat = 1;
    end else if (!st) begin
      e_lat = 2; e_rd_cyc = 1;
      if (size == 0) begin
        e_rdata = {24'd0, b[off]};
        if (f3 < 4 && b[off] >= 8'd128) e_rdata = e_rdata | 32'hFFFF_FF00;
      end else if (size == 1) begin
        e_rdata = {16'd0, b[off+1], b[off]};
        if (f3 < 4 && b[off+1] >= 8'd128) e_rdata = e_rdata | 32'hFFFF_0000;
      end else begin
        e_rdata = {b[3], b[2], b[1], b[0]};
      end
    end else if (size == 2) begin
      e_lat = 2; e_wr_cyc = 1;
      ref_mem[wi] = wd;
    end else begin
      e_lat = 3; e_rd_cyc = 1; e_wr_cyc = 2;
      b[off] = wd[7:0];
      if (size == 1) b[off+1] = wd[15:8];
      ref_mem[wi] = {b[3], b[2], b[1], b[0]};
    end
  endtask

  // Issue one request from IDLE (called at a negedge) and check its response.
  task automatic run_req(input string tag, input bit st, input int f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit inject);
    bit e_err; logic [31:0] e_rdata; int e_lat, e_rd_cyc, e_wr_cyc;
    int cyc, n_rd, n_wr, rd_cyc, wr_cyc, wi;
    bit seen;
    model(st, f3, a, wd, e_err, e_rdata, e_lat, e_rd_cyc, e_wr_cyc);
    wi = int'((a / 4) % NWORDS);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    req = 1'b1; is_store = st; funct3 = 3'(f3); addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    cyc = 1; n_rd = 0; n_wr = 0; rd_cyc = 0; wr_cyc = 0; seen = 0;
    while (cyc <= 8) begin
      if (mem_read)  begin n_rd++; if (rd_cyc == 0) rd_cyc = cyc; end
      if (mem_write) begin n_wr++; if (wr_cyc == 0) wr_cyc = cyc; end
      if (mem_read && mem_write) check({tag, "_rw_overlap"}, 32'd1, 32'd0);
      if (inject && cyc == 1) begin
        req = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h14; wdata = 32'hDEAD_BEEF;
      end
      if (inject && cyc == 2) req = 1'b0;
      if (done) begin seen = 1; break; end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(e_lat));
    check({tag, "_err"}, 32'(err), 32'(e_err));
    check({tag, "_rdata"}, rdata, e_rdata);
    check({tag, "_n_reads"}, 32'(n_rd), 32'(e_rd_cyc != 0));
    check({tag, "_n_writes"}, 32'(n_wr), 32'(e_wr_cyc != 0));
    check({tag, "_rd_cycle"}, 32'(rd_cyc), 32'(e_rd_cyc));
    check({tag, "_wr_cycle"}, 32'(wr_cyc), 32'(e_wr_cyc));
    check({tag, "_mem_word"}, mem[wi], ref_mem[wi]);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_rdata_held"}, rdata, e_rdata);
    check({tag, "_err_held"}, 32'(err), 32'(e_err));
    if (inject) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check({tag, "_no_extra_done"}, 32'(done), 32'd0);
      end
      check({tag, "_word5_untouched"}, mem[5], ref_mem[5]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int f3;
    bit st;
    logic [31:0] a;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = $urandom();
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'h0000_00F0; ref_mem[1] = 32'h0000_00F0;
    mem[2] = 32'h1122_3344; ref_mem[2] = 32'h1122_3344;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_funct3", 32'(mem_funct3), 32'd2);
    rst_n = 1'b1;
    @(negedge clk);

    run_req("lb_5", 1'b0, 0, 32'h5, 32'd0, 1'b0);
    check("tp_lb_5", rdata, 32'h0000_0000);
    run_req("lb_4", 1'b0, 0, 32'h4, 32'd0, 1'b0);
    check("tp_lb_4", rdata, 32'hFFFF_FFF0);
    run_req("lbu_4", 1'b0, 4, 32'h4, 32'd0, 1'b0);
    check("tp_lbu_4", rdata, 32'h0000_00F0);
    run_req("sb_a", 1'b1, 0, 32'hA, 32'hAB, 1'b0);
    check("tp_sb_word2", mem[2], 32'h11AB_3344);
    run_req("lw_8", 1'b0, 2, 32'h8, 32'd0, 1'b0);
    check("tp_lw_8", rdata, 32'h11AB_3344);
    run_req("sh_6", 1'b1, 1, 32'h6, 32'hBEEF, 1'b0);
    check("tp_sh_word1", mem[1], 32'hBEEF_00F0);
    run_req("lh_6", 1'b0, 1, 32'h6, 32'd0, 1'b0);
    check("tp_lh_6", rdata, 32'hFFFF_BEEF);
    run_req("lhu_6", 1'b0, 5, 32'h6, 32'd0, 1'b0);
    check("tp_lhu_6", rdata, 32'h0000_BEEF);
    run_req("lw_mis", 1'b0, 2, 32'h2, 32'd0, 1'b0);
    run_req("sh_mis", 1'b1, 1, 32'h3, 32'h1234, 1'b0);
    run_req("ld_ill", 1'b0, 3, 32'h0, 32'd0, 1'b0);
    run_req("st_ill", 1'b1, 4, 32'h0, 32'h55, 1'b0);
    run_req("sb_busy_req", 1'b1, 0, 32'h9, 32'h5A, 1'b1);

    // Abort an SW in its WRITE cycle.
    run_req("lw_pre", 1'b0, 2, 32'h10, 32'd0, 1'b0);
    req = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("abort_in_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_mem_read", 32'(mem_read), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_word_kept", mem[4], ref_mem[4]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end

    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = int'($urandom_range(0, 7));
      else if (st) f3 = int'($urandom_range(0, 2));
      else begin
        f3 = int'($urandom_range(0, 4));
        if (f3 == 3) f3 = 5;
      end
      a = $urandom();
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3 % 4 == 2) ? 2'b00 : ((f3 % 4 == 1) ? {a[1], 1'b0} : a[1:0]);
      run_req("rand", st, f3, a, $urandom(), 1'b0);
    end

    for (int i = 0; i < NWORDS; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
